// File: rtl/gpr_operand_fetch.sv
// Operand fetch for the GPR file: sequences up to three reads over one registered read port,
// merges writeback bytes; n reads -> out_valid after n+2 cycles (1 if none); holds output until out_ready.
module gpr_operand_fetch #(
   parameter bit ZERO_BYPASS = 1'b0,
   parameter int TidMSB      = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [TidMSB:0]   in_tid,
   input  logic [31:0]       in_ir,
   input  logic [5:0]        in_ra,
   input  logic [5:0]        in_rb,
   input  logic [5:0]        in_rc,
   input  logic [2:0]        in_use,
   output logic [TidMSB+6:0] rf_ra,
   input  logic [31:0]       rf_o,
   input  logic [3:0]        wb_wr,
   input  logic [TidMSB+6:0] wb_wa,
   input  logic [31:0]       wb_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TidMSB:0]   out_tid,
   output logic [31:0]       out_ir,
   output logic [31:0]       out_a,
   output logic [31:0]       out_b,
   output logic [31:0]       out_c
);

   typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

   state_t           state;
   logic [TidMSB:0]  tid_q;
   logic [31:0]      ir_q;
   logic [5:0]       rn_q [3];
   logic [1:0]       lst [3];
   logic [1:0]       cnt;
   logic [1:0]       idx;
   logic [1:0]       prev;
   logic             prev_vld;
   logic [2:0]       capd;
   logic [31:0]      opnd [3];

   logic [5:0]       rn_in [3];
   logic [1:0]       nlst [3];
   logic [1:0]       ncnt;

   assign rn_in = '{in_ra, in_rb, in_rc};

   // Fetch list: used sources in a, b, c order, skipping r0 when it is hardwired to zero.
   always_comb begin
      nlst = '{default: 2'd0};
      ncnt = 2'd0;
      for (int s = 0; s < 3; s++) begin
         if (in_use[s] && !(ZERO_BYPASS && rn_in[s] == 6'd0)) begin
            nlst[ncnt] = s[1:0];
            ncnt       = ncnt + 2'd1;
         end
      end
   end

   always_comb begin
      rf_ra = '0;
      case (state)
         RD:      rf_ra = {tid_q, rn_q[lst[idx]]};
         CAP:     rf_ra = {tid_q, rn_q[prev]};
         default: rf_ra = '0;
      endcase
   end

   function automatic logic [31:0] merge(input logic [31:0] base, input logic [TidMSB+6:0] addr);
      for (int k = 0; k < 4; k++)
         merge[8*k +: 8] = (wb_wr[k] && wb_wa == addr) ? wb_i[8*k +: 8] : base[8*k +: 8];
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         tid_q    <= '0;
         ir_q     <= '0;
         rn_q     <= '{default: 6'd0};
         lst      <= '{default: 2'd0};
         cnt      <= 2'd0;
         idx      <= 2'd0;
         prev     <= 2'd0;
         prev_vld <= 1'b0;
         capd     <= 3'b000;
         opnd     <= '{default: 32'd0};
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               tid_q    <= in_tid;
               ir_q     <= in_ir;
               rn_q     <= rn_in;
               lst      <= nlst;
               cnt      <= ncnt;
               idx      <= 2'd0;
               prev_vld <= 1'b0;
               capd     <= 3'b000;
               opnd     <= '{default: 32'd0};
               state    <= (ncnt != 2'd0) ? RD : OUT;
            end
            RD, CAP: begin
               // Held operands track writebacks; the capture below overrides its own slot.
               for (int s = 0; s < 3; s++)
                  if (capd[s]) opnd[s] <= merge(opnd[s], {tid_q, rn_q[s]});
               if (prev_vld || state == CAP) begin
                  opnd[prev] <= merge(rf_o, {tid_q, rn_q[prev]});
                  capd[prev] <= 1'b1;
               end
               if (state == RD) begin
                  prev     <= lst[idx];
                  prev_vld <= 1'b1;
                  idx      <= idx + 2'd1;
                  if (idx == cnt - 2'd1) state <= CAP;
               end else begin
                  prev_vld <= 1'b0;
                  state    <= OUT;
               end
            end
            OUT: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = rst_n && (state == IDLE);
   assign out_valid = (state == OUT);
   assign out_tid   = tid_q;
   assign out_ir    = ir_q;
   assign out_a     = opnd[0];
   assign out_b     = opnd[1];
   assign out_c     = opnd[2];

endmodule

// File: tb/tb_gpr_operand_fetch.sv
// Directed bench for gpr_operand_fetch with a behavioural register file; a second
// instance with ZERO_BYPASS=1 shares all inputs.
module tb_gpr_operand_fetch;
   localparam int TM = 2;

   logic clk = 1'b0;
   logic rst_n, in_valid, out_ready;
   logic [TM:0] in_tid;
   logic [31:0] in_ir, wb_i;
   logic [5:0] in_ra, in_rb, in_rc;
   logic [2:0] in_use;
   logic [3:0] wb_wr;
   logic [TM+6:0] wb_wa;

   logic in_ready, out_valid, z_in_ready, z_out_valid;
   logic [TM+6:0] rf_ra, z_rf_ra;
   logic [31:0] rf_o, z_rf_o;
   logic [TM:0] out_tid, z_out_tid;
   logic [31:0] out_ir, out_a, out_b, out_c, z_out_ir, z_out_a, z_out_b, z_out_c;

   logic [31:0] mem [512];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rf_o   <= mem[rf_ra];
      z_rf_o <= mem[z_rf_ra];
   end

   gpr_operand_fetch #(.ZERO_BYPASS(1'b0), .TidMSB(TM)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_tid(in_tid), .in_ir(in_ir), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
      .in_use(in_use), .rf_ra(rf_ra), .rf_o(rf_o), .wb_wr(wb_wr), .wb_wa(wb_wa),
      .wb_i(wb_i), .out_valid(out_valid), .out_ready(out_ready), .out_tid(out_tid),
      .out_ir(out_ir), .out_a(out_a), .out_b(out_b), .out_c(out_c));

   gpr_operand_fetch #(.ZERO_BYPASS(1'b1), .TidMSB(TM)) dut_zb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
      .in_tid(in_tid), .in_ir(in_ir), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
      .in_use(in_use), .rf_ra(z_rf_ra), .rf_o(z_rf_o), .wb_wr(wb_wr), .wb_wa(wb_wa),
      .wb_i(wb_i), .out_valid(z_out_valid), .out_ready(out_ready), .out_tid(z_out_tid),
      .out_ir(z_out_ir), .out_a(z_out_a), .out_b(z_out_b), .out_c(z_out_c));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [TM:0] tid, input logic [31:0] ir, input logic [5:0] ra,
                        input logic [5:0] rb, input logic [5:0] rc, input logic [2:0] use_m);
      in_valid = 1'b1; in_tid = tid; in_ir = ir;
      in_ra = ra; in_rb = rb; in_rc = rc; in_use = use_m;
   endtask

   task automatic finish_out();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0;
      step(); step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (rf_ra !== '0) begin errors++; $display("FAIL rst_rf_ra got %h exp 0", rf_ra); end
      checks++; if ({out_a, out_b, out_c, out_ir} !== 128'd0 || out_tid !== '0) begin errors++; $display("FAIL rst_payload got %h %h %h %h exp 0", out_a, out_b, out_c, out_ir); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_three_src();
      drive(3'd2, 32'hC0DE0001, 6'd1, 6'd2, 6'd3, 3'b111);
      step(); in_valid = 1'b0;
      checks++; if (rf_ra !== {3'd2, 6'd1}) begin errors++; $display("FAIL three_rf_ra1 got %h exp %h", rf_ra, {3'd2, 6'd1}); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL three_in_ready got %b exp 0", in_ready); end
      step();
      checks++; if (rf_ra !== {3'd2, 6'd2}) begin errors++; $display("FAIL three_rf_ra2 got %h exp %h", rf_ra, {3'd2, 6'd2}); end
      step();
      checks++; if (rf_ra !== {3'd2, 6'd3}) begin errors++; $display("FAIL three_rf_ra3 got %h exp %h", rf_ra, {3'd2, 6'd3}); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL three_early_valid got %b exp 0", out_valid); end
      step();
      checks++; if (out_valid !== 1'b1 || z_out_valid !== 1'b1) begin errors++; $display("FAIL three_valid got %b/%b exp 1/1", out_valid, z_out_valid); end
      checks++; if (out_a !== 32'h11111111 || out_b !== 32'h22222222 || out_c !== 32'h33333333) begin errors++; $display("FAIL three_operands got %h %h %h exp 11111111 22222222 33333333", out_a, out_b, out_c); end
      checks++; if (out_tid !== 3'd2 || out_ir !== 32'hC0DE0001) begin errors++; $display("FAIL three_payload got %h %h exp 2 c0de0001", out_tid, out_ir); end
      finish_out();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL three_return_idle got rdy %b vld %b exp 1 0", in_ready, out_valid); end
   endtask

   task automatic test_no_src();
      drive(3'd5, 32'h0000AAAA, 6'd4, 6'd5, 6'd6, 3'b000);
      step(); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nosrc_valid got %b exp 1", out_valid); end
      checks++; if (rf_ra !== '0) begin errors++; $display("FAIL nosrc_rf_ra got %h exp 0", rf_ra); end
      checks++; if ({out_a, out_b, out_c} !== 96'd0) begin errors++; $display("FAIL nosrc_operands got %h %h %h exp 0", out_a, out_b, out_c); end
      checks++; if (out_tid !== 3'd5 || out_ir !== 32'h0000AAAA) begin errors++; $display("FAIL nosrc_payload got %h %h exp 5 0000aaaa", out_tid, out_ir); end
      finish_out();
   endtask

   task automatic test_zero_bypass();
      drive(3'd1, 32'h2B000000, 6'd0, 6'd5, 6'd9, 3'b011);
      step(); in_valid = 1'b0;
      checks++; if (z_rf_ra !== {3'd1, 6'd5}) begin errors++; $display("FAIL zb_rf_ra got %h exp %h", z_rf_ra, {3'd1, 6'd5}); end
      checks++; if (rf_ra !== {3'd1, 6'd0}) begin errors++; $display("FAIL nozb_rf_ra got %h exp %h", rf_ra, {3'd1, 6'd0}); end
      step();
      checks++; if (z_out_valid !== 1'b0) begin errors++; $display("FAIL zb_early_valid got %b exp 0", z_out_valid); end
      step();
      checks++; if (z_out_valid !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL zb_valid got %b/%b exp 1/0", z_out_valid, out_valid); end
      checks++; if (z_out_a !== 32'd0 || z_out_b !== 32'h55555555) begin errors++; $display("FAIL zb_operands got %h %h exp 0 55555555", z_out_a, z_out_b); end
      step();
      checks++; if (out_valid !== 1'b1 || out_a !== 32'hDEADBEEF || out_b !== 32'h55555555) begin errors++; $display("FAIL nozb_operands got %b %h %h exp 1 deadbeef 55555555", out_valid, out_a, out_b); end
      finish_out();
   endtask

   task automatic test_wb_capture();
      drive(3'd3, 32'h1A000000, 6'd7, 6'd0, 6'd0, 3'b001);
      step(); in_valid = 1'b0;
      step();
      wb_wr = 4'b0101; wb_wa = {3'd3, 6'd7}; wb_i = 32'hAABBCCDD;
      step();
      checks++; if (out_valid !== 1'b1 || out_a !== 32'h11BB33DD) begin errors++; $display("FAIL wbcap_a got %b %h exp 1 11bb33dd", out_valid, out_a); end
      wb_wr = 4'b1111;
      step();
      wb_wr = 4'b0000;
      checks++; if (out_a !== 32'h11BB33DD) begin errors++; $display("FAIL wbcap_out_nomerge got %h exp 11bb33dd", out_a); end
      finish_out();
   endtask

   task automatic test_wb_held();
      drive(3'd2, 32'h3C000000, 6'd1, 6'd2, 6'd3, 3'b111);
      step(); in_valid = 1'b0;
      step();
      step();
      wb_wr = 4'b0101; wb_wa = {3'd2, 6'd1}; wb_i = 32'hAABBCCDD;
      step();
      wb_wr = 4'b0000;
      step();
      checks++; if (out_valid !== 1'b1 || out_a !== 32'h11BB11DD) begin errors++; $display("FAIL wbheld_a got %b %h exp 1 11bb11dd", out_valid, out_a); end
      checks++; if (out_b !== 32'h22222222 || out_c !== 32'h33333333) begin errors++; $display("FAIL wbheld_bc got %h %h exp 22222222 33333333", out_b, out_c); end
      finish_out();
   endtask

   task automatic test_backpressure();
      drive(3'd6, 32'h0BAD0006, 6'd0, 6'd0, 6'd0, 3'b000);
      step();
      in_ir = 32'h12345678; in_tid = 3'd4;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", out_valid); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_tid !== 3'd6 || out_ir !== 32'h0BAD0006) begin errors++; $display("FAIL bp_hold%0d got vld %b rdy %b %h %h exp 1 0 6 0bad0006", i, out_valid, in_ready, out_tid, out_ir); end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got rdy %b vld %b exp 1 0", in_ready, out_valid); end
      step(); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_ir !== 32'h12345678 || out_tid !== 3'd4) begin errors++; $display("FAIL bp_next got %b %h %h exp 1 12345678 4", out_valid, out_ir, out_tid); end
      finish_out();
   endtask

   task automatic test_reset_mid();
      drive(3'd2, 32'h4D000000, 6'd1, 6'd2, 6'd3, 3'b111);
      step(); in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || rf_ra !== '0) begin errors++; $display("FAIL rstmid_ctrl got vld %b rdy %b ra %h exp 0 0 0", out_valid, in_ready, rf_ra); end
      checks++; if ({out_a, out_b, out_c, out_ir} !== 128'd0 || out_tid !== '0) begin errors++; $display("FAIL rstmid_payload got %h %h %h %h exp 0", out_a, out_b, out_c, out_ir); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release got %b exp 1", in_ready); end
      test_three_src();
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'hA5000000 | i;
      mem[{3'd2, 6'd1}] = 32'h11111111;
      mem[{3'd2, 6'd2}] = 32'h22222222;
      mem[{3'd2, 6'd3}] = 32'h33333333;
      mem[{3'd1, 6'd0}] = 32'hDEADBEEF;
      mem[{3'd1, 6'd5}] = 32'h55555555;
      mem[{3'd3, 6'd7}] = 32'h11223344;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_tid = '0; in_ir = '0; in_ra = '0; in_rb = '0; in_rc = '0; in_use = '0;
      wb_wr = '0; wb_wa = '0; wb_i = '0;
      test_reset();
      test_three_src();
      test_no_src();
      test_zero_bypass();
      test_wb_capture();
      test_wb_held();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
